// File: rtl/skin_bbox.sv
// ---------------------------------------------------------------------------
// skin_bbox
//   Sits directly after rgb2hsv in the neuro_skin HDMI path. Every pixel is
//   classified as skin / non-skin with inclusive H, S and V windows. The mask
//   is forwarded together with de/hsync/vsync delayed by one enabled cycle.
//   Alongside, the skin bounding box and skin pixel count of each frame are
//   accumulated and latched at every vsync rising edge for the tracking and
//   overlay logic.
//
// Ports
//   clk, rst        pixel clock, synchronous active-high reset
//   ce              clock enable; every register holds while low
//   de_in           active-video enable from rgb2hsv
//   hsync_in        horizontal sync (delayed only)
//   vsync_in        vertical sync, active high; rising edge = frame boundary
//   H, S, V         8-bit hue / saturation / value
//   mask_out        1 = skin pixel (always 0 when de was low)
//   de_out, hsync_out, vsync_out   inputs delayed to line up with mask_out
//   frame_done      one-cycle pulse when new frame results are latched
//   found           latched pix_count >= MIN_COUNT
//   x_min, x_max    latched bbox columns (0 when found = 0)
//   y_min, y_max    latched bbox rows    (0 when found = 0)
//   pix_count       latched skin pixel count, saturating
// ---------------------------------------------------------------------------
module skin_bbox #(
    parameter logic [7:0] H_MIN     = 8'd0,
    parameter logic [7:0] H_MAX     = 8'd25,
    parameter logic [7:0] S_MIN     = 8'd40,
    parameter logic [7:0] S_MAX     = 8'd170,
    parameter logic [7:0] V_MIN     = 8'd60,
    parameter logic [7:0] V_MAX     = 8'd255,
    parameter int         XW        = 11,
    parameter int         YW        = 11,
    parameter int         CW        = 21,
    parameter int         MIN_COUNT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [7:0]    H,
    input  logic [7:0]    S,
    input  logic [7:0]    V,
    output logic          mask_out,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          frame_done,
    output logic          found,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic [CW-1:0] pix_count
);

    localparam logic [XW-1:0] X_SAT   = '1;
    localparam logic [YW-1:0] Y_SAT   = '1;
    localparam logic [CW-1:0] CNT_SAT = '1;

    // A MIN_COUNT beyond what the saturating counter can represent can never
    // be met, so found is then held at 0 instead of comparing against a
    // truncated threshold.
    localparam int            CNT_LIMIT     = (1 << CW) - 1;
    localparam bit            MIN_REACHABLE = (MIN_COUNT <= CNT_LIMIT);
    localparam logic [CW-1:0] MIN_CNT       = MIN_REACHABLE ? CW'(MIN_COUNT) : '0;

    // Channel order inside the packed vectors: [0]=H, [1]=S, [2]=V.
    localparam logic [2:0][7:0] WIN_LO   = {V_MIN, S_MIN, H_MIN};
    localparam logic [2:0][7:0] WIN_SPAN = {V_MAX - V_MIN, S_MAX - S_MIN, H_MAX - H_MIN};

    logic [2:0][7:0] chan;
    logic [2:0]      in_win;
    logic            skin;
    logic            vs_rise;
    logic            de_fall;

    logic            de_prev_reg;
    logic            vsync_prev_reg;
    logic            primed_reg;
    logic [XW-1:0]   x_reg,         x_next;
    logic [YW-1:0]   y_reg,         y_next;
    logic [XW-1:0]   acc_min_x_reg, acc_min_x_next;
    logic [XW-1:0]   acc_max_x_reg, acc_max_x_next;
    logic [YW-1:0]   acc_min_y_reg, acc_min_y_next;
    logic [YW-1:0]   acc_max_y_reg, acc_max_y_next;
    logic [CW-1:0]   acc_cnt_reg,   acc_cnt_next;
    logic            found_next;

    assign chan = {V, S, H};

    // Inclusive window test as a single unsigned compare: (val - lo) wraps to
    // a large value whenever val < lo, so one "<= span" covers both bounds.
    // Requires lo <= hi for every channel.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_win
            logic [7:0] offset;
            assign offset     = chan[gi] - WIN_LO[gi];
            assign in_win[gi] = (offset <= WIN_SPAN[gi]);
        end
    endgenerate

    assign skin    = de_in & (&in_win);
    assign vs_rise = vsync_in & ~vsync_prev_reg;
    assign de_fall = ~de_in & de_prev_reg;

    // Coordinates of the pixel currently on the inputs.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (de_in) begin
            if (x_reg != X_SAT) x_next = x_reg + 1'b1;
        end else if (de_fall) begin
            x_next = '0;
        end
        if (vs_rise) begin
            y_next = '0;
        end else if (de_fall && (y_reg != Y_SAT)) begin
            y_next = y_reg + 1'b1;
        end
    end

    // Accumulators. On a frame boundary they restart from their empty values
    // first, so a skin pixel arriving on that same cycle becomes the first
    // contribution to the new frame rather than the closing one.
    always_comb begin
        acc_min_x_next = acc_min_x_reg;
        acc_max_x_next = acc_max_x_reg;
        acc_min_y_next = acc_min_y_reg;
        acc_max_y_next = acc_max_y_reg;
        acc_cnt_next   = acc_cnt_reg;
        if (vs_rise) begin
            acc_min_x_next = '1;
            acc_max_x_next = '0;
            acc_min_y_next = '1;
            acc_max_y_next = '0;
            acc_cnt_next   = '0;
        end
        if (skin) begin
            if (x_reg < acc_min_x_next) acc_min_x_next = x_reg;
            if (x_reg > acc_max_x_next) acc_max_x_next = x_reg;
            if (y_reg < acc_min_y_next) acc_min_y_next = y_reg;
            if (y_reg > acc_max_y_next) acc_max_y_next = y_reg;
            if (acc_cnt_next != CNT_SAT) acc_cnt_next = acc_cnt_next + 1'b1;
        end
    end

    assign found_next = MIN_REACHABLE && (acc_cnt_reg >= MIN_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_out       <= 1'b0;
            de_out         <= 1'b0;
            hsync_out      <= 1'b0;
            vsync_out      <= 1'b0;
            frame_done     <= 1'b0;
            found          <= 1'b0;
            x_min          <= '0;
            x_max          <= '0;
            y_min          <= '0;
            y_max          <= '0;
            pix_count      <= '0;
            de_prev_reg    <= 1'b0;
            vsync_prev_reg <= 1'b0;
            primed_reg     <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            acc_min_x_reg  <= '1;
            acc_max_x_reg  <= '0;
            acc_min_y_reg  <= '1;
            acc_max_y_reg  <= '0;
            acc_cnt_reg    <= '0;
        end else begin
            // Pulse output: drops on any cycle that is not an enabled latch.
            frame_done <= 1'b0;
            if (ce) begin
                mask_out       <= skin;
                de_out         <= de_in;
                hsync_out      <= hsync_in;
                vsync_out      <= vsync_in;
                de_prev_reg    <= de_in;
                vsync_prev_reg <= vsync_in;
                x_reg          <= x_next;
                y_reg          <= y_next;
                acc_min_x_reg  <= acc_min_x_next;
                acc_max_x_reg  <= acc_max_x_next;
                acc_min_y_reg  <= acc_min_y_next;
                acc_max_y_reg  <= acc_max_y_next;
                acc_cnt_reg    <= acc_cnt_next;
                if (vs_rise) begin
                    // The first boundary after reset only opens a frame;
                    // there is no complete frame behind it to report.
                    primed_reg <= 1'b1;
                    if (primed_reg) begin
                        frame_done <= 1'b1;
                        found      <= found_next;
                        pix_count  <= acc_cnt_reg;
                        x_min      <= found_next ? acc_min_x_reg : '0;
                        x_max      <= found_next ? acc_max_x_reg : '0;
                        y_min      <= found_next ? acc_min_y_reg : '0;
                        y_max      <= found_next ? acc_max_y_reg : '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_skin_bbox.sv
// ---------------------------------------------------------------------------
// tb_skin_bbox
//   Drives synthetic video frames into three skin_bbox instances that share
//   one stimulus stream: default parameters, MIN_COUNT=1 and CW=4. A
//   frame-level reference model keeps the skin pixels seen per frame (by the
//   row/column the bench placed them at) and derives bbox/count/found from
//   plain min/max/count arithmetic.
// ---------------------------------------------------------------------------
module tb_skin_bbox;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ce, de_in, hsync_in, vsync_in;
    logic [7:0] H, S, V;

    logic        m_mask, m_de, m_hs, m_vs, m_fd, m_found;
    logic [10:0] m_xmin, m_xmax, m_ymin, m_ymax;
    logic [20:0] m_pix;
    logic        o_mask, o_de, o_hs, o_vs, o_fd, o_found;
    logic [10:0] o_xmin, o_xmax, o_ymin, o_ymax;
    logic [20:0] o_pix;
    logic        c_mask, c_de, c_hs, c_vs, c_fd, c_found;
    logic [10:0] c_xmin, c_xmax, c_ymin, c_ymax;
    logic [3:0]  c_pix;

    skin_bbox u_main (
        .clk(clk), .rst(rst), .ce(ce), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .H(H), .S(S), .V(V), .mask_out(m_mask), .de_out(m_de), .hsync_out(m_hs), .vsync_out(m_vs),
        .frame_done(m_fd), .found(m_found), .x_min(m_xmin), .x_max(m_xmax), .y_min(m_ymin),
        .y_max(m_ymax), .pix_count(m_pix)
    );

    skin_bbox #(.MIN_COUNT(1)) u_min1 (
        .clk(clk), .rst(rst), .ce(ce), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .H(H), .S(S), .V(V), .mask_out(o_mask), .de_out(o_de), .hsync_out(o_hs), .vsync_out(o_vs),
        .frame_done(o_fd), .found(o_found), .x_min(o_xmin), .x_max(o_xmax), .y_min(o_ymin),
        .y_max(o_ymax), .pix_count(o_pix)
    );

    skin_bbox #(.CW(4)) u_cw4 (
        .clk(clk), .rst(rst), .ce(ce), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .H(H), .S(S), .V(V), .mask_out(c_mask), .de_out(c_de), .hsync_out(c_hs), .vsync_out(c_vs),
        .frame_done(c_fd), .found(c_found), .x_min(c_xmin), .x_max(c_xmax), .y_min(c_ymin),
        .y_max(c_ymax), .pix_count(c_pix)
    );

    int checks = 0;
    int errors = 0;
    bit ce_rand = 1'b0;

    // Reference model state
    bit          m_primed, m_vs_prev;
    int          acc_n, acc_mnx, acc_mxx, acc_mny, acc_mxy;
    logic [65:0] exp_m, exp_1, exp_4;
    logic        last_done;
    bit          skin_map [0:63][0:63];

    // Packed results: {found, x_min, x_max, y_min, y_max, pix_count(21b)}
    function automatic logic [65:0] pk_main();
        return {m_found, m_xmin, m_xmax, m_ymin, m_ymax, m_pix};
    endfunction
    function automatic logic [65:0] pk_min1();
        return {o_found, o_xmin, o_xmax, o_ymin, o_ymax, o_pix};
    endfunction
    function automatic logic [65:0] pk_cw4();
        return {c_found, c_xmin, c_xmax, c_ymin, c_ymax, 17'd0, c_pix};
    endfunction

    function automatic logic [65:0] make_exp(int mincount, int cw);
        int lim, sat;
        lim = (1 << cw) - 1;
        sat = (acc_n > lim) ? lim : acc_n;
        if (sat >= mincount)
            return {1'b1, 11'(acc_mnx), 11'(acc_mxx), 11'(acc_mny), 11'(acc_mxy), 21'(sat)};
        return {1'b0, 44'd0, 21'(sat)};
    endfunction

    function automatic bit is_skin(logic d, logic [7:0] h, logic [7:0] s, logic [7:0] v);
        return d && (h <= 8'd25) && (s >= 8'd40) && (s <= 8'd170) && (v >= 8'd60);
    endfunction

    task automatic clear_acc();
        acc_n = 0; acc_mnx = 99999; acc_mxx = -1; acc_mny = 99999; acc_mxy = -1;
    endtask

    task automatic rand_hsv(input bit want_skin, output logic [7:0] h, output logic [7:0] s,
                            output logic [7:0] v);
        h = 8'($urandom_range(0, 25));
        s = 8'($urandom_range(40, 170));
        v = 8'($urandom_range(60, 255));
        if (!want_skin) begin
            case ($urandom_range(0, 3))
                0: h = 8'($urandom_range(26, 255));
                1: s = 8'($urandom_range(0, 39));
                2: s = 8'($urandom_range(171, 255));
                default: v = 8'($urandom_range(0, 59));
            endcase
        end
    endtask

    // One pixel, held until an enabled clock edge consumes it.
    task automatic send(input logic d, input logic vs, input logic hs, input logic [7:0] h,
                        input logic [7:0] s, input logic [7:0] v, input int col, input int row);
        bit took, rise, expd, sk;
        de_in = d; vsync_in = vs; hsync_in = hs; H = h; S = s; V = v;
        rise = vs && !m_vs_prev;
        expd = rise && m_primed;
        sk   = is_skin(d, h, s, v);
        took = 1'b0;
        while (!took) begin
            ce   = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            took = ce;
            @(posedge clk); #1;
            if (!took) begin
                checks++;
                if (m_fd !== 1'b0) begin
                    errors++;
                    $display("FAIL done_while_ce_low got=%b exp=0", m_fd);
                end
            end
        end
        checks++;
        if ({m_mask, m_de, m_hs, m_vs} !== {sk, d, hs, vs}) begin
            errors++;
            $display("FAIL pipeline mask/de/hs/vs got=%b%b%b%b exp=%b%b%b%b (H=%0d S=%0d V=%0d)",
                     m_mask, m_de, m_hs, m_vs, sk, d, hs, vs, h, s, v);
        end
        checks++;
        if (m_fd !== expd) begin
            errors++;
            $display("FAIL frame_done got=%b exp=%b", m_fd, expd);
        end
        if (rise) begin
            if (m_primed) begin
                exp_m = make_exp(16, 21);
                exp_1 = make_exp(1, 21);
                exp_4 = make_exp(16, 4);
            end
            m_primed = 1'b1;
            clear_acc();
        end
        if (sk) begin
            acc_n++;
            if (col < acc_mnx) acc_mnx = col;
            if (col > acc_mxx) acc_mxx = col;
            if (row < acc_mny) acc_mny = row;
            if (row > acc_mxy) acc_mxy = row;
        end
        m_vs_prev = vs;
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b1; de_in = 1'b0; vsync_in = 1'b0; hsync_in = 1'b0;
        H = 8'd0; S = 8'd0; V = 8'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_primed = 1'b0; m_vs_prev = 1'b0;
        clear_acc();
        exp_m = '0; exp_1 = '0; exp_4 = '0;
    endtask

    task automatic vsync_pulse();
        send(1'b0, 1'b1, 1'b0, 8'd10, 8'd100, 8'd100, 0, 0);
        last_done = m_fd;
        send(1'b0, 1'b1, 1'b0, 8'd10, 8'd100, 8'd100, 0, 0);
        send(1'b0, 1'b0, 1'b0, 8'd10, 8'd100, 8'd100, 0, 0);
        send(1'b0, 1'b0, 1'b0, 8'd10, 8'd100, 8'd100, 0, 0);
    endtask

    task automatic fill_map(input int w, input int h, input int n);
        int placed, c, r;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++) skin_map[i][j] = 1'b0;
        placed = 0;
        while (placed < n) begin
            c = $urandom_range(0, w - 1);
            r = $urandom_range(0, h - 1);
            if (!skin_map[r][c]) begin
                skin_map[r][c] = 1'b1;
                placed++;
            end
        end
    endtask

    // mode 0: no skin, 1: block cols 100..139 rows 20..29, 2: single (5,3),
    // 3: skin_map. abort_at > 0 stops once that many skin pixels were sent.
    task automatic drive_frame(input int w, input int h, input int mode, input int abort_at);
        logic [7:0] hh, ss, vv;
        bit sk;
        for (int i = 0; i < 3; i++) begin
            rand_hsv(1'b1, hh, ss, vv);
            send(1'b0, 1'b0, 1'b0, hh, ss, vv, 0, 0);
        end
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                case (mode)
                    1: sk = (c >= 100) && (c <= 139) && (r >= 20) && (r <= 29);
                    2: sk = (c == 5) && (r == 3);
                    3: sk = skin_map[r][c];
                    default: sk = 1'b0;
                endcase
                rand_hsv(sk, hh, ss, vv);
                send(1'b1, 1'b0, 1'b0, hh, ss, vv, c, r);
                if (abort_at > 0 && acc_n >= abort_at) return;
            end
            for (int b = 0; b < 4; b++) begin
                rand_hsv($urandom_range(0, 1) == 1, hh, ss, vv);
                send(1'b0, 1'b0, (b == 1 || b == 2), hh, ss, vv, 0, 0);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({m_mask, m_de, m_hs, m_vs, m_fd} !== 5'b0 || pk_main() !== 66'd0) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b%b%b res=%h exp=all0",
                     m_mask, m_de, m_hs, m_vs, m_fd, pk_main());
        end
    endtask

    task automatic test_boundary();
        logic [7:0] vec [5][3];
        logic       dv  [5];
        logic       exp [5];
        vec[0] = '{8'd25, 8'd40, 8'd60}; dv[0] = 1'b1; exp[0] = 1'b1;
        vec[1] = '{8'd26, 8'd40, 8'd60}; dv[1] = 1'b1; exp[1] = 1'b0;
        vec[2] = '{8'd25, 8'd39, 8'd60}; dv[2] = 1'b1; exp[2] = 1'b0;
        vec[3] = '{8'd25, 8'd40, 8'd59}; dv[3] = 1'b1; exp[3] = 1'b0;
        vec[4] = '{8'd25, 8'd40, 8'd60}; dv[4] = 1'b0; exp[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(dv[i], 1'b0, 1'b0, vec[i][0], vec[i][1], vec[i][2], i, 0);
            checks++;
            if (m_mask !== exp[i]) begin
                errors++;
                $display("FAIL boundary_%0d mask got=%b exp=%b", i, m_mask, exp[i]);
            end
        end
        send(1'b1, 1'b0, 1'b0, 8'd0, 8'd170, 8'd255, 5, 0);
        checks++;
        if (m_mask !== 1'b1) begin
            errors++;
            $display("FAIL boundary_upper mask got=%b exp=1", m_mask);
        end
        send(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 0, 0);
    endtask

    task automatic test_single();
        vsync_pulse();
        checks++;
        if (last_done !== 1'b0) begin
            errors++;
            $display("FAIL single_prime_done got=%b exp=0", last_done);
        end
        drive_frame(8, 4, 2, 0);
        vsync_pulse();
        checks++;
        if (last_done !== 1'b1 || pk_min1() !== {1'b1, 11'd5, 11'd5, 11'd3, 11'd3, 21'd1}) begin
            errors++;
            $display("FAIL single_min1 done=%b got=%h exp=%h", last_done, pk_min1(),
                     {1'b1, 11'd5, 11'd5, 11'd3, 11'd3, 21'd1});
        end
        checks++;
        if (pk_main() !== {1'b0, 44'd0, 21'd1}) begin
            errors++;
            $display("FAIL single_main got=%h exp=%h", pk_main(), {1'b0, 44'd0, 21'd1});
        end
    endtask

    task automatic test_block();
        drive_frame(640, 30, 1, 0);
        vsync_pulse();
        checks++;
        if (last_done !== 1'b1 || pk_main() !== {1'b1, 11'd100, 11'd139, 11'd20, 11'd29, 21'd400}) begin
            errors++;
            $display("FAIL block_main done=%b got=%h exp=%h", last_done, pk_main(),
                     {1'b1, 11'd100, 11'd139, 11'd20, 11'd29, 21'd400});
        end
        checks++;
        if (pk_cw4() !== {1'b0, 44'd0, 21'd15}) begin
            errors++;
            $display("FAIL block_cw4 got=%h exp=%h", pk_cw4(), {1'b0, 44'd0, 21'd15});
        end
    endtask

    task automatic test_empty();
        drive_frame(16, 4, 0, 0);
        vsync_pulse();
        checks++;
        if (last_done !== 1'b1 || pk_main() !== 66'd0 || pk_min1() !== 66'd0) begin
            errors++;
            $display("FAIL empty done=%b got=%h/%h exp=0", last_done, pk_main(), pk_min1());
        end
        fill_map(16, 6, 10);
        drive_frame(16, 6, 3, 0);
        vsync_pulse();
        checks++;
        if (pk_main() !== {1'b0, 44'd0, 21'd10}) begin
            errors++;
            $display("FAIL ten_px_main got=%h exp=%h", pk_main(), {1'b0, 44'd0, 21'd10});
        end
        checks++;
        if (pk_min1() !== exp_1) begin
            errors++;
            $display("FAIL ten_px_min1 got=%h exp=%h", pk_min1(), exp_1);
        end
    endtask

    task automatic test_ce_toggle();
        ce_rand = 1'b1;
        drive_frame(200, 30, 1, 0);
        vsync_pulse();
        checks++;
        if (last_done !== 1'b1 || pk_main() !== {1'b1, 11'd100, 11'd139, 11'd20, 11'd29, 21'd400}) begin
            errors++;
            $display("FAIL ce_block done=%b got=%h exp=%h", last_done, pk_main(),
                     {1'b1, 11'd100, 11'd139, 11'd20, 11'd29, 21'd400});
        end
        fill_map(40, 20, 20);
        drive_frame(40, 20, 3, 0);
        vsync_pulse();
        checks++;
        if (pk_cw4() !== {1'b0, 44'd0, 21'd15}) begin
            errors++;
            $display("FAIL cw4_sat got=%h exp=%h", pk_cw4(), {1'b0, 44'd0, 21'd15});
        end
        checks++;
        if (pk_main() !== exp_m || pk_min1() !== exp_1) begin
            errors++;
            $display("FAIL ce_rand_frame got=%h/%h exp=%h/%h", pk_main(), pk_min1(), exp_m, exp_1);
        end
        ce_rand = 1'b0;
    endtask

    task automatic test_mid_reset();
        fill_map(32, 8, 60);
        drive_frame(32, 8, 3, 50);
        do_reset();
        checks++;
        if (pk_main() !== 66'd0 || pk_min1() !== 66'd0 || pk_cw4() !== 66'd0 ||
            {m_mask, m_de, m_hs, m_vs, m_fd} !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset got=%h/%h/%h flags=%b%b%b%b%b exp=0", pk_main(), pk_min1(),
                     pk_cw4(), m_mask, m_de, m_hs, m_vs, m_fd);
        end
        vsync_pulse();
        checks++;
        if (last_done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_prime done got=%b exp=0", last_done);
        end
        fill_map(24, 6, 18);
        drive_frame(24, 6, 3, 0);
        vsync_pulse();
        checks++;
        if (last_done !== 1'b1 || pk_main() !== exp_m || exp_m[20:0] !== 21'd18) begin
            errors++;
            $display("FAIL post_reset_frame done=%b got=%h exp=%h", last_done, pk_main(), exp_m);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(0, 30);
            fill_map(30, 10, n);
            drive_frame(30, 10, 3, 0);
            vsync_pulse();
            checks++;
            if (pk_main() !== exp_m || pk_min1() !== exp_1 || pk_cw4() !== exp_4) begin
                errors++;
                $display("FAIL b2b_%0d n=%0d got=%h/%h/%h exp=%h/%h/%h", k, n, pk_main(),
                         pk_min1(), pk_cw4(), exp_m, exp_1, exp_4);
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_boundary();
        test_single();
        test_block();
        test_empty();
        test_ce_toggle();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
